// File: rtl/moxie_pkg.sv
// Shared definitions for the Moxie core: FSM states, ALU operations,
// condition flags, opcodes, register indices and branch-condition codes.
package moxie_pkg;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_MOV,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOT,
        ALU_NEG,
        ALU_MUL,
        ALU_LSHR,
        ALU_ASHL,
        ALU_ASHR
    } alu_op_t;

    typedef struct packed {
        logic eq;
        logic lt;
        logic ltu;
    } flags_t;

    // Architectural register indices
    localparam int REG_FP = 0;
    localparam int REG_SP = 1;

    // Instruction form selector, ir[15:14]
    localparam logic [1:0] FORM_1   = 2'b00;
    localparam logic [1:0] FORM_ILL = 2'b01;
    localparam logic [1:0] FORM_2   = 2'b10;
    localparam logic [1:0] FORM_3   = 2'b11;

    // Form 1 opcodes, ir[15:8]
    localparam logic [7:0] OP_BAD  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_MOV  = 8'h02;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_LDA  = 8'h08;
    localparam logic [7:0] OP_STA  = 8'h09;
    localparam logic [7:0] OP_LD   = 8'h0a;
    localparam logic [7:0] OP_ST   = 8'h0b;
    localparam logic [7:0] OP_CMP  = 8'h0e;
    localparam logic [7:0] OP_NOP  = 8'h0f;
    localparam logic [7:0] OP_JMPA = 8'h1a;
    localparam logic [7:0] OP_JMP  = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h26;
    localparam logic [7:0] OP_LSHR = 8'h27;
    localparam logic [7:0] OP_ASHL = 8'h28;
    localparam logic [7:0] OP_SUB  = 8'h29;
    localparam logic [7:0] OP_NEG  = 8'h2a;
    localparam logic [7:0] OP_OR   = 8'h2b;
    localparam logic [7:0] OP_NOT  = 8'h2c;
    localparam logic [7:0] OP_ASHR = 8'h2d;
    localparam logic [7:0] OP_XOR  = 8'h2e;
    localparam logic [7:0] OP_MUL  = 8'h2f;
    localparam logic [7:0] OP_BRK  = 8'h35;

    // Form 3 branch conditions, ir[13:10]; 10..15 are never taken
    localparam logic [3:0] CC_BEQ  = 4'd0;
    localparam logic [3:0] CC_BNE  = 4'd1;
    localparam logic [3:0] CC_BLT  = 4'd2;
    localparam logic [3:0] CC_BGT  = 4'd3;
    localparam logic [3:0] CC_BLTU = 4'd4;
    localparam logic [3:0] CC_BGTU = 4'd5;
    localparam logic [3:0] CC_BGE  = 4'd6;
    localparam logic [3:0] CC_BLE  = 4'd7;
    localparam logic [3:0] CC_BGEU = 4'd8;
    localparam logic [3:0] CC_BLEU = 4'd9;

    function automatic logic branch_taken(input logic [3:0] cc, input flags_t f);
        logic taken;
        case (cc)
            CC_BEQ:  taken = f.eq;
            CC_BNE:  taken = !f.eq;
            CC_BLT:  taken = f.lt;
            CC_BGT:  taken = !f.lt && !f.eq;
            CC_BLTU: taken = f.ltu;
            CC_BGTU: taken = !f.ltu && !f.eq;
            CC_BGE:  taken = !f.lt;
            CC_BLE:  taken = f.lt || f.eq;
            CC_BGEU: taken = !f.ltu;
            CC_BLEU: taken = f.ltu || f.eq;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/moxie_alu_if.sv
// Operand/result bundle between the core's execute logic and the ALU.
interface moxie_alu_if;
    import moxie_pkg::*;

    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;

    modport master (output op, a, b, input result);
    modport slave  (input op, a, b, output result);
endinterface

// File: rtl/moxie_alu.sv
// Combinational 32-bit ALU for the register-register Form 1 instructions.
// Everything is modulo 2^32; shifts use only b[4:0].
module moxie_alu
    import moxie_pkg::*;
(
    moxie_alu_if.slave bus
);

    logic signed [31:0] a_s;
    logic        [31:0] result;

    assign a_s        = $signed(bus.a);
    assign bus.result = result;

    // Select the operation result
    always_comb begin
        result = bus.b;
        case (bus.op)
            ALU_MOV:  result = bus.b;
            ALU_ADD:  result = bus.a + bus.b;
            ALU_SUB:  result = bus.a - bus.b;
            ALU_AND:  result = bus.a & bus.b;
            ALU_OR:   result = bus.a | bus.b;
            ALU_XOR:  result = bus.a ^ bus.b;
            ALU_NOT:  result = ~bus.b;
            ALU_NEG:  result = 32'd0 - bus.b;
            ALU_MUL:  result = bus.a * bus.b;
            ALU_LSHR: result = bus.a >> bus.b[4:0];
            ALU_ASHL: result = bus.a << bus.b[4:0];
            ALU_ASHR: result = $unsigned(a_s >>> bus.b[4:0]);
            default:  result = bus.b;
        endcase
    end

endmodule

// File: rtl/moxie_core.sv
// Multi-cycle Moxie subset core with built-in unified byte memory.
// Every instruction is FETCH (2-byte opcode) then EXEC; HALT only leaves on reset.
module moxie_core
    import moxie_pkg::*;
#(
    parameter int    MEM_BYTES = 4096,
    parameter string INIT_FILE = "moxie.hex"
) (
    input logic rst_i,
    input logic clk_i
);

    localparam int AW = $clog2(MEM_BYTES);

    // Architectural and FSM state
    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir_pc;
    logic [15:0] ir;
    logic [31:0] regs [0:15];
    flags_t      flags;
    logic        halted;

    logic [7:0]  mem [0:MEM_BYTES-1];

    // Big-endian 32-bit read, each byte address wrapping independently
    function automatic logic [31:0] rd32(input logic [AW-1:0] a);
        return {mem[a], mem[a + AW'(1)], mem[a + AW'(2)], mem[a + AW'(3)]};
    endfunction

    // Instruction fields and operands
    logic [7:0]         opcode;
    logic [3:0]         ra;
    logic [3:0]         rb;
    logic [31:0]        va;
    logic [31:0]        vb;
    logic signed [31:0] va_s;
    logic signed [31:0] vb_s;
    logic [31:0]        imm8;
    logic [31:0]        br_off;
    logic [AW-1:0]      pc_a;
    logic [15:0]        fetch_ir;
    logic [31:0]        imm32;
    logic [AW-1:0]      ld_addr;
    logic [31:0]        load_data;

    assign opcode   = ir[15:8];
    assign ra       = ir[7:4];
    assign rb       = ir[3:0];
    assign va       = regs[ra];
    assign vb       = regs[rb];
    assign va_s     = $signed(va);
    assign vb_s     = $signed(vb);
    assign imm8     = {24'h0, ir[7:0]};
    assign br_off   = {{21{ir[9]}}, ir[9:0], 1'b0};
    assign pc_a     = pc[AW-1:0];
    assign fetch_ir = {mem[pc_a], mem[pc_a + AW'(1)]};
    assign imm32    = rd32(pc_a);
    assign ld_addr  = (opcode == OP_LDA) ? imm32[AW-1:0] : vb[AW-1:0];
    assign load_data = rd32(ld_addr);

    // ALU
    moxie_alu_if alu_bus ();
    alu_op_t     alu_op;
    logic        alu_wr;
    logic        illegal;

    assign alu_bus.op = alu_op;
    assign alu_bus.a  = va;
    assign alu_bus.b  = vb;

    moxie_alu u_alu (
        .bus (alu_bus.slave)
    );

    // Decode: ALU operation, ALU writeback and illegal-instruction detection
    always_comb begin
        alu_op  = ALU_MOV;
        alu_wr  = 1'b0;
        illegal = 1'b0;
        if (ir[15:14] == FORM_1) begin
            case (opcode)
                OP_MOV:  begin alu_op = ALU_MOV;  alu_wr = 1'b1; end
                OP_ADD:  begin alu_op = ALU_ADD;  alu_wr = 1'b1; end
                OP_SUB:  begin alu_op = ALU_SUB;  alu_wr = 1'b1; end
                OP_AND:  begin alu_op = ALU_AND;  alu_wr = 1'b1; end
                OP_OR:   begin alu_op = ALU_OR;   alu_wr = 1'b1; end
                OP_XOR:  begin alu_op = ALU_XOR;  alu_wr = 1'b1; end
                OP_NOT:  begin alu_op = ALU_NOT;  alu_wr = 1'b1; end
                OP_NEG:  begin alu_op = ALU_NEG;  alu_wr = 1'b1; end
                OP_MUL:  begin alu_op = ALU_MUL;  alu_wr = 1'b1; end
                OP_LSHR: begin alu_op = ALU_LSHR; alu_wr = 1'b1; end
                OP_ASHL: begin alu_op = ALU_ASHL; alu_wr = 1'b1; end
                OP_ASHR: begin alu_op = ALU_ASHR; alu_wr = 1'b1; end
                OP_LDI, OP_CMP, OP_LDA, OP_STA, OP_LD, OP_ST,
                OP_JMPA, OP_JMP, OP_NOP: illegal = 1'b0;
                OP_BAD, OP_BRK: illegal = 1'b1;
                default: illegal = 1'b1;
            endcase
        end else if (ir[15:14] == FORM_ILL) begin
            illegal = 1'b1;
        end
    end

    // Store port request; only asserted in EXEC, so an async reset
    // (which forces FETCH) suppresses any pending store.
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    // Select store address and data for sta.l / st.l
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = imm32[AW-1:0];
        mem_wdata = va;
        if (state == EXEC && ir[15:14] == FORM_1) begin
            if (opcode == OP_STA) begin
                mem_we    = 1'b1;
                mem_waddr = imm32[AW-1:0];
                mem_wdata = va;
            end else if (opcode == OP_ST) begin
                mem_we    = 1'b1;
                mem_waddr = va[AW-1:0];
                mem_wdata = vb;
            end
        end
    end

    // Memory write port: big-endian 32-bit store, addresses wrap
    always @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr]          <= mem_wdata[31:24];
            mem[mem_waddr + AW'(1)] <= mem_wdata[23:16];
            mem[mem_waddr + AW'(2)] <= mem_wdata[15:8];
            mem[mem_waddr + AW'(3)] <= mem_wdata[7:0];
        end
    end

    // Fetch/execute state machine with register file and flags
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= FETCH;
            pc           <= 32'h0;
            ir           <= 16'h0;
            ir_pc        <= 32'h0;
            flags        <= '0;
            halted       <= 1'b0;
            regs[REG_FP] <= 32'h0;
            regs[REG_SP] <= 32'(MEM_BYTES);
            for (int i = 2; i < 16; i++) begin
                regs[i] <= 32'h0;
            end
        end else begin
            case (state)
                FETCH: begin
                    ir    <= fetch_ir;
                    ir_pc <= pc;
                    pc    <= pc + 32'd2;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    if (illegal) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        $display("HALT pc=%h ir=%h", ir_pc, ir);
                    end else begin
                        case (ir[15:14])
                            FORM_1: begin
                                if (alu_wr) begin
                                    regs[ra] <= alu_bus.result;
                                end
                                case (opcode)
                                    OP_LDI: begin
                                        regs[ra] <= imm32;
                                        pc       <= pc + 32'd4;
                                    end
                                    OP_CMP: begin
                                        flags.eq  <= (va == vb);
                                        flags.lt  <= (va_s < vb_s);
                                        flags.ltu <= (va < vb);
                                    end
                                    OP_LDA: begin
                                        regs[ra] <= load_data;
                                        pc       <= pc + 32'd4;
                                    end
                                    OP_STA:  pc <= pc + 32'd4;
                                    OP_LD:   regs[ra] <= load_data;
                                    OP_JMPA: pc <= imm32;
                                    OP_JMP:  pc <= va;
                                    default: ;
                                endcase
                            end
                            FORM_2: begin
                                regs[ir[11:8]] <= ir[12] ? regs[ir[11:8]] - imm8
                                                         : regs[ir[11:8]] + imm8;
                            end
                            FORM_3: begin
                                if (branch_taken(ir[13:10], flags)) begin
                                    pc <= pc + br_off;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_moxie_core.sv
// Directed bench for moxie_core: programs are poked into dut.mem while reset
// is held, then architectural state is inspected hierarchically.
module tb_moxie_core;
    import moxie_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    moxie_core #(
        .MEM_BYTES (4096),
        .INIT_FILE ("")
    ) dut (
        .rst_i (rst_n),
        .clk_i (clk)
    );

    moxie_alu_if tb_alu ();
    moxie_alu u_alu_alone (
        .bus (tb_alu.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] prog [$];

    typedef struct {
        logic [7:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic p8(input logic [7:0] b);
        prog.push_back(b);
    endtask

    task automatic p16(input logic [15:0] w);
        p8(w[15:8]);
        p8(w[7:0]);
    endtask

    task automatic p32(input logic [31:0] w);
        p16(w[31:16]);
        p16(w[15:0]);
    endtask

    task automatic ldi(input logic [3:0] r, input logic [31:0] v);
        p8(8'h01);
        p8({r, 4'h0});
        p32(v);
    endtask

    // Hold reset, clear memory, load the program queue, release on a negedge.
    task automatic start();
        rst_n = 1'b0;
        for (int i = 0; i < 4096; i++) dut.mem[i] = 8'h00;
        foreach (prog[i]) dut.mem[i] = prog[i];
        prog.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_halt(input int limit, output int cycles);
        cycles = 0;
        while (!dut.halted && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    function automatic logic [31:0] mem32(input int a);
        return {dut.mem[a], dut.mem[(a + 1) % 4096], dut.mem[(a + 2) % 4096], dut.mem[(a + 3) % 4096]};
    endfunction

    initial begin
        int cyc;

        vecs[0]  = '{8'h05, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
        vecs[1]  = '{8'h29, 32'h00000003, 32'h00000005, 32'hFFFFFFFE};
        vecs[2]  = '{8'h26, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
        vecs[3]  = '{8'h2b, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
        vecs[4]  = '{8'h2e, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        vecs[5]  = '{8'h2c, 32'h12345678, 32'h0000FFFF, 32'hFFFF0000};
        vecs[6]  = '{8'h2a, 32'h12345678, 32'h00000001, 32'hFFFFFFFF};
        vecs[7]  = '{8'h2f, 32'h00010000, 32'h00010001, 32'h00010000};
        vecs[8]  = '{8'h27, 32'h80000000, 32'h00000024, 32'h08000000};
        vecs[9]  = '{8'h28, 32'h00000001, 32'h0000001F, 32'h80000000};
        vecs[10] = '{8'h2d, 32'h80000000, 32'h00000004, 32'hF8000000};
        vecs[11] = '{8'h02, 32'h11111111, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[12] = '{8'h0e, 32'h00000005, 32'h00000005, 32'h00000005};

        // Reset state and first fetch, then add.l result after 6 cycles
        ldi(4'd2, 32'h12345678);
        ldi(4'd3, 32'h0000000A);
        p16(16'h0523);
        start();
        check("rst_pc", dut.pc, 32'h0);
        check("rst_sp", dut.regs[1], 32'd4096);
        check("rst_fp", dut.regs[0], 32'h0);
        check("rst_r0", dut.regs[2], 32'h0);
        check("rst_flags", 32'(dut.flags), 32'h0);
        check("rst_halted", 32'(dut.halted), 32'h0);
        check("rst_state", 32'(dut.state), 32'(FETCH));
        run(1);
        check("fetch1_ir", 32'(dut.ir), 32'h0120);
        check("fetch1_pc", dut.pc, 32'h2);
        run(5);
        check("add_r0", dut.regs[2], 32'h12345682);
        check("add_r1", dut.regs[3], 32'h0000000A);
        check("add_pc", dut.pc, 32'd14);

        // Form 1 register ops through the core, table-driven
        for (int i = 0; i < 13; i++) begin
            ldi(4'd2, vecs[i].a);
            ldi(4'd3, vecs[i].b);
            p8(vecs[i].opc);
            p8(8'h23);
            start();
            run(6);
            check($sformatf("op%h_result", vecs[i].opc), dut.regs[2], vecs[i].exp);
        end

        // Standalone ALU through the interface
        tb_alu.op = ALU_ASHR; tb_alu.a = 32'h80000000; tb_alu.b = 32'd31; #1;
        check("alu_ashr31", tb_alu.result, 32'hFFFFFFFF);
        tb_alu.op = ALU_SUB; tb_alu.a = 32'h0; tb_alu.b = 32'h1; #1;
        check("alu_sub_wrap", tb_alu.result, 32'hFFFFFFFF);

        // sta.l / lda.l round trip
        ldi(4'd2, 32'h12345678);
        p16(16'h0920); p32(32'h00000800);
        p16(16'h0840); p32(32'h00000800);
        start();
        run(6);
        check("sta_mem", mem32(32'h800), 32'h12345678);
        check("sta_byte0", 32'(dut.mem[12'h800]), 32'h12);
        check("lda_r2", dut.regs[4], 32'h12345678);

        // cmp -1,1 then blt (taken), bltu (not taken), bne (taken)
        ldi(4'd2, 32'hFFFFFFFF);
        ldi(4'd3, 32'h00000001);
        p16(16'h0e23);
        p16(16'hC801);   // blt +1
        p16(16'h8701);   // inc $r5,1
        p16(16'hD001);   // bltu +1
        p16(16'h8801);   // inc $r6,1
        p16(16'hC401);   // bne +1
        p16(16'h8901);   // inc $r7,1
        p16(16'h0000);
        start();
        run(20);
        check("cmp_eq", 32'(dut.flags.eq), 32'h0);
        check("cmp_lt", 32'(dut.flags.lt), 32'h1);
        check("cmp_ltu", 32'(dut.flags.ltu), 32'h0);
        check("blt_taken", dut.regs[7], 32'h0);
        check("bltu_not_taken", dut.regs[8], 32'h1);
        check("bne_taken", dut.regs[9], 32'h0);
        check("br_halt_pc", dut.pc, 32'd28);

        // Counted loop: dec / cmp / bne backwards
        p16(16'h8505);   // inc $r3,5
        p16(16'h9501);   // loop: dec $r3,1
        p16(16'h8801);   // inc $r6,1
        p16(16'h0e56);   // cmp $r3,$r4
        p16(16'hC7FC);   // bne loop (-4)
        p16(16'h0000);
        start();
        wait_halt(200, cyc);
        check("loop_halted", 32'(dut.halted), 32'h1);
        check("loop_cycles", 32'(cyc), 32'd44);
        check("loop_r3", dut.regs[5], 32'h0);
        check("loop_count", dut.regs[8], 32'd5);
        check("loop_pc", dut.pc, 32'd12);

        // st.l, ld.l, wrapping sta.l and jmpa
        ldi(4'd2, 32'h00000800);
        ldi(4'd3, 32'hCAFEF00D);
        p16(16'h0b23);
        p16(16'h0a42);
        p16(16'h0930); p32(32'h00001FFE);
        p16(16'h1a00); p32(32'h00000040);
        start();
        wait_halt(50, cyc);
        check("ldst_cycles", 32'(cyc), 32'd14);
        check("st_mem", mem32(32'h800), 32'hCAFEF00D);
        check("ld_r2", dut.regs[4], 32'hCAFEF00D);
        check("sta_wrap", mem32(32'hFFE), 32'hCAFEF00D);
        check("jmpa_pc", dut.pc, 32'h42);

        // jmp to a zero opcode: halts and pc stays put
        ldi(4'd2, 32'h00000030);
        p16(16'h2520);
        start();
        run(4);
        check("jmp_pc", dut.pc, 32'h30);
        run(2);
        check("bad_halted", 32'(dut.halted), 32'h1);
        check("bad_pc", dut.pc, 32'h32);
        run(5);
        check("halt_pc_frozen", dut.pc, 32'h32);
        check("halt_state", 32'(dut.state), 32'(HALT));

        // brk halts; mov $r0,$r0 leaves $r0 alone
        ldi(4'd2, 32'h00000055);
        p16(16'h0222);
        p16(16'h3500);
        start();
        run(6);
        check("mov_self", dut.regs[2], 32'h55);
        check("brk_halted", 32'(dut.halted), 32'h1);

        // st.l completes when not interrupted
        ldi(4'd2, 32'h00000800);
        ldi(4'd3, 32'hAABBCCDD);
        p16(16'h0b23);
        start();
        run(6);
        check("st_full", mem32(32'h800), 32'hAABBCCDD);

        // Same program, reset asserted during the st.l EXEC cycle
        ldi(4'd2, 32'h00000800);
        ldi(4'd3, 32'hAABBCCDD);
        p16(16'h0b23);
        start();
        run(5);
        check("st_in_exec", 32'(dut.state), 32'(EXEC));
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", dut.pc, 32'h0);
        check("async_rst_state", 32'(dut.state), 32'(FETCH));
        @(posedge clk);
        #1;
        check("rst_abort_st", mem32(32'h800), 32'h0);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
